// File: rtl/rv32_mc_control.sv
// Multicycle RV32 control unit: instruction-class FSM driving datapath selects and
// enables, with a sticky illegal-opcode flag and a retired-instruction counter.
module rv32_mc_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             zero_i,
  input  logic             lt_i,
  input  logic             ltu_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic             adr_src_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       imm_src_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       result_src_o,
  output logic             retire_o,
  output logic             trap_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  state_t           state_q, state_d;
  logic             trap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             taken;

  // Branch condition from funct3 and the ALU flags
  always_comb begin
    taken = 1'b0;
    case (funct3_i)
      3'b000:  taken = zero_i;
      3'b001:  taken = !zero_i;
      3'b100:  taken = lt_i;
      3'b101:  taken = !lt_i;
      3'b110:  taken = ltu_i;
      3'b111:  taken = !ltu_i;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= (state_d == S_TRAP);
      if (retire_o) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Datapath controls decoded from the current state; enables are gated by reset
  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    imm_src_o    = 3'b000;
    alu_op_o     = 2'b00;
    result_src_o = 2'b00;
    retire_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_BR:    imm_src_o = 3'b010;
          OP_JAL:   imm_src_o = 3'b011;
          OP_AUIPC: imm_src_o = 3'b100;
          default:  imm_src_o = 3'b000;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = (op_i == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        retire_o    = mem_ready_i;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_write_o  = taken;
        retire_o    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      S_JALR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_LUI: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b01;
        imm_src_o   = 3'b100;
      end
      default: ;
    endcase
    if (rst_i) begin
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
      retire_o    = 1'b0;
    end
  end

  assign state_o      = state_q;
  assign trap_o       = trap_q;
  assign retire_cnt_o = cnt_q;

endmodule
